// File: rtl/operand_sequencer_pkg.sv
// Shared encodings for the operand sequencer and the solver controller bench.
// Holds FSM state codes, solver select bit positions and the select decoder.
package operand_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_GAP    = 3'd2,
        ST_ARM    = 3'd3,
        ST_WAIT   = 3'd4,
        ST_REPORT = 3'd5
    } state_e;

    localparam int SEL_X  = 0;
    localparam int SEL_DX = 1;
    localparam int SEL_A  = 2;
    localparam int SEL_U  = 3;

    localparam int NUM_OPS  = 4;
    localparam int TIMER_W  = 16;

    function automatic logic [NUM_OPS-1:0] sel_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/operand_sequencer_wait.sv
// Solver response timer: counts enabled cycles and flags the edge on which
// the count reaches the programmed limit.
module wait_timer
    import operand_sequencer_pkg::*;
#(
    parameter int CW = TIMER_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    input  logic [CW-1:0] limit,
    output logic          expired
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [CW:0]   count_inc;

    assign count_inc = {1'b0, count_q} + {{CW{1'b0}}, 1'b1};

    // Asserted on the edge where this increment would land on the limit.
    assign expired = enable && (count_inc >= {1'b0, limit});

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != limit)) begin
            count_d = count_inc[CW-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/operand_sequencer.sv
// Streams four latched operands to the solver one select strobe at a time,
// then fires the go strobe and waits for the result or a timeout.
module operand_sequencer
    import operand_sequencer_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int HOLD    = 2,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] dx_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] u_in,
    output logic             busy,
    output logic [3:0]       sel,
    output logic [WIDTH-1:0] data_out,
    output logic             ready,
    input  logic             dut_valid,
    input  logic [WIDTH-1:0] dut_result,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             timeout
);

    state_e state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] hold_q, hold_d;

    logic [NUM_OPS-1:0][WIDTH-1:0] ops_q, ops_d;

    logic             busy_q, busy_d;
    logic [3:0]       sel_q, sel_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ready_q, ready_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;
    logic             to_q, to_d;

    logic tmr_clear;
    logic tmr_enable;
    logic tmr_expired;

    assign tmr_clear  = (state_q != ST_WAIT);
    assign tmr_enable = (state_q == ST_WAIT) && !dut_valid;

    wait_timer #(
        .CW(TIMER_W)
    ) u_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (tmr_clear),
        .enable (tmr_enable),
        .limit  (TIMER_W'(TIMEOUT)),
        .expired(tmr_expired)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        hold_d   = hold_q;
        ops_d    = ops_q;
        result_d = result_q;
        sel_d    = '0;
        data_d   = '0;
        ready_d  = 1'b0;
        done_d   = 1'b0;
        to_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ops_d[SEL_X]  = x_in;
                    ops_d[SEL_DX] = dx_in;
                    ops_d[SEL_A]  = a_in;
                    ops_d[SEL_U]  = u_in;
                    idx_d   = '0;
                    hold_d  = '0;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                sel_d  = sel_onehot(idx_q);
                data_d = ops_q[idx_q];
                if (hold_q == 4'(HOLD - 1)) begin
                    hold_d  = '0;
                    state_d = ST_GAP;
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            ST_GAP: begin
                if (idx_q == 2'(SEL_U)) begin
                    state_d = ST_ARM;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = ST_DRIVE;
                end
            end
            ST_ARM: begin
                ready_d = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A result on the expiry edge still counts as a completion.
                if (dut_valid) begin
                    result_d = dut_result;
                    state_d  = ST_REPORT;
                end else if (tmr_expired) begin
                    to_d    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_REPORT: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort && (state_q != ST_IDLE)) begin
            state_d  = ST_IDLE;
            idx_d    = '0;
            hold_d   = '0;
            result_d = result_q;
            sel_d    = '0;
            data_d   = '0;
            ready_d  = 1'b0;
            done_d   = 1'b0;
            to_d     = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            hold_q   <= '0;
            ops_q    <= '0;
            busy_q   <= 1'b0;
            sel_q    <= '0;
            data_q   <= '0;
            ready_q  <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            hold_q   <= hold_d;
            ops_q    <= ops_d;
            busy_q   <= busy_d;
            sel_q    <= sel_d;
            data_q   <= data_d;
            ready_q  <= ready_d;
            result_q <= result_d;
            done_q   <= done_d;
            to_q     <= to_d;
        end
    end

    assign busy     = busy_q;
    assign sel      = sel_q;
    assign data_out = data_q;
    assign ready    = ready_q;
    assign result   = result_q;
    assign done     = done_q;
    assign timeout  = to_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Scoreboard bench for operand_sequencer: stimulus queues expected output
// events with their cycle stamps; a monitor pops and compares them.
module tb_operand_sequencer;

    localparam int W    = 16;
    localparam int HOLD = 2;
    localparam int TO   = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] x_in = '0;
    logic [W-1:0] dx_in = '0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] u_in = '0;
    logic         dut_valid = 1'b0;
    logic [W-1:0] dut_result = '0;
    logic         busy;
    logic [3:0]   sel;
    logic [W-1:0] data_out;
    logic         ready;
    logic [W-1:0] result;
    logic         done;
    logic         timeout;

    operand_sequencer #(
        .WIDTH  (W),
        .HOLD   (HOLD),
        .TIMEOUT(TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .x_in      (x_in),
        .dx_in     (dx_in),
        .a_in      (a_in),
        .u_in      (u_in),
        .busy      (busy),
        .sel       (sel),
        .data_out  (data_out),
        .ready     (ready),
        .dut_valid (dut_valid),
        .dut_result(dut_result),
        .result    (result),
        .done      (done),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           c;
        logic [3:0]   sel;
        logic [W-1:0] data;
        logic         rdy;
        logic         dn;
        logic         to;
        logic [W-1:0] res;
    } ev_t;

    ev_t          exp_q[$];
    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] cur_res = '0;

    task automatic push_ev(input int c, input logic [3:0] s,
                           input logic [W-1:0] d, input logic r,
                           input logic dn, input logic to,
                           input logic [W-1:0] res);
        ev_t e;
        e.c = c; e.sel = s; e.data = d;
        e.rdy = r; e.dn = dn; e.to = to; e.res = res;
        exp_q.push_back(e);
    endtask

    task automatic push_ops(input int t0, input int n,
                            input logic [W-1:0] x, input logic [W-1:0] dx,
                            input logic [W-1:0] a, input logic [W-1:0] u);
        logic [W-1:0] op[4];
        op[0] = x; op[1] = dx; op[2] = a; op[3] = u;
        for (int i = 0; i < n; i++)
            for (int h = 0; h < HOLD; h++)
                push_ev(t0 + i*(HOLD+1) + 1 + h, 4'(1 << i), op[i],
                        1'b0, 1'b0, 1'b0, cur_res);
    endtask

    task automatic push_ready(input int t0);
        push_ev(t0 + 4*(HOLD+1) + 1, 4'd0, '0, 1'b1, 1'b0, 1'b0, cur_res);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic at_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic run_start(input logic [W-1:0] x, input logic [W-1:0] dx,
                             input logic [W-1:0] a, input logic [W-1:0] u,
                             output int t0);
        x_in = x; dx_in = dx; a_in = a; u_in = u;
        start = 1'b1;
        t0 = cyc + 1;
    endtask

    task automatic dv_at(input int n, input logic [W-1:0] v);
        at_cyc(n - 1);
        dut_valid = 1'b1;
        dut_result = v;
        at_cyc(n);
        dut_valid = 1'b0;
        dut_result = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_sel"}, 32'(sel), 32'd0);
        chk({tag, "_data"}, 32'(data_out), 32'd0);
        chk({tag, "_ready"}, 32'(ready), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_timeout"}, 32'(timeout), 32'd0);
        chk({tag, "_result"}, 32'(result), 32'd0);
    endtask

    // Monitor: every visible output event must match the queue head.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (!reset && (sel != 4'd0 || ready || done || timeout)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got cyc=%0d sel=%b data=%h rdy=%b done=%b to=%b, want none",
                             cyc, sel, data_out, ready, done, timeout);
                end else begin
                    e = exp_q.pop_front();
                    if (e.c != cyc || sel !== e.sel || data_out !== e.data ||
                        ready !== e.rdy || done !== e.dn ||
                        timeout !== e.to || result !== e.res) begin
                        errors++;
                        $display("FAIL event: got cyc=%0d sel=%b data=%h rdy=%b done=%b to=%b res=%h, want cyc=%0d sel=%b data=%h rdy=%b done=%b to=%b res=%h",
                                 cyc, sel, data_out, ready, done, timeout, result,
                                 e.c, e.sel, e.data, e.rdy, e.dn, e.to, e.res);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");

        // Nominal run, started on the first edge after reset release.
        reset = 1'b0;
        run_start(16'h0010, 16'h0001, 16'h0003, 16'h0005, t0);
        push_ops(t0, 4, 16'h0010, 16'h0001, 16'h0003, 16'h0005);
        push_ready(t0);
        push_ev(t0 + 19, 4'd0, '0, 1'b0, 1'b1, 1'b0, 16'h00AB);
        at_cyc(t0);
        start = 1'b0;
        chk("nom_busy_on", 32'(busy), 32'd1);
        dv_at(t0 + 18, 16'h00AB);
        at_cyc(t0 + 19);
        chk("nom_result", 32'(result), 32'h00AB);
        chk("nom_busy_off", 32'(busy), 32'd0);
        cur_res = 16'h00AB;

        // Back-to-back start: timeout with no solver response.
        run_start(16'h1111, 16'h2222, 16'h3333, 16'h4444, t0);
        push_ops(t0, 4, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        push_ready(t0);
        push_ev(t0 + 21, 4'd0, '0, 1'b0, 1'b0, 1'b1, cur_res);
        at_cyc(t0);
        start = 1'b0;
        at_cyc(t0 + 22);
        chk("to_busy_off", 32'(busy), 32'd0);
        chk("to_result_kept", 32'(result), 32'h00AB);

        // Result on the exact expiry edge.
        run_start(16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D, t0);
        push_ops(t0, 4, 16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D);
        push_ready(t0);
        push_ev(t0 + 22, 4'd0, '0, 1'b0, 1'b1, 1'b0, 16'h00CD);
        at_cyc(t0);
        start = 1'b0;
        dv_at(t0 + 21, 16'h00CD);
        at_cyc(t0 + 23);
        chk("coin_result", 32'(result), 32'h00CD);
        cur_res = 16'h00CD;

        // Start and dut_valid while driving dx must be ignored.
        run_start(16'h0010, 16'h0001, 16'h0003, 16'h0005, t0);
        push_ops(t0, 4, 16'h0010, 16'h0001, 16'h0003, 16'h0005);
        push_ready(t0);
        push_ev(t0 + 16, 4'd0, '0, 1'b0, 1'b1, 1'b0, 16'h1234);
        at_cyc(t0);
        start = 1'b0;
        at_cyc(t0 + 3);
        start = 1'b1;
        x_in = 16'hFFFF; dx_in = 16'hEEEE; a_in = 16'hDDDD; u_in = 16'hCCCC;
        dut_valid = 1'b1;
        dut_result = 16'h5555;
        at_cyc(t0 + 4);
        start = 1'b0;
        dut_valid = 1'b0;
        dut_result = '0;
        dv_at(t0 + 15, 16'h1234);
        at_cyc(t0 + 17);
        chk("busy_start_result", 32'(result), 32'h1234);
        cur_res = 16'h1234;

        // Abort while the a operand is on the bus.
        run_start(16'h0007, 16'h0008, 16'h0009, 16'h000A, t0);
        push_ops(t0, 2, 16'h0007, 16'h0008, 16'h0009, 16'h000A);
        push_ev(t0 + 7, 4'b0100, 16'h0009, 1'b0, 1'b0, 1'b0, cur_res);
        at_cyc(t0);
        start = 1'b0;
        at_cyc(t0 + 7);
        abort = 1'b1;
        at_cyc(t0 + 8);
        abort = 1'b0;
        chk("abort_sel", 32'(sel), 32'd0);
        chk("abort_data", 32'(data_out), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_result", 32'(result), 32'h1234);
        at_cyc(t0 + 16);

        // Reset asserted in WAIT clears outputs at once.
        run_start(16'h00F0, 16'h00F1, 16'h00F2, 16'h00F3, t0);
        push_ops(t0, 4, 16'h00F0, 16'h00F1, 16'h00F2, 16'h00F3);
        push_ready(t0);
        at_cyc(t0);
        start = 1'b0;
        at_cyc(t0 + 16);
        #2 reset = 1'b1;
        #1 chk_all_zero("midreset");
        at_cyc(t0 + 18);
        reset = 1'b0;
        cur_res = '0;

        // Start accepted on the first edge after reset release.
        run_start(16'h0101, 16'h0202, 16'h0303, 16'h0404, t0);
        push_ops(t0, 4, 16'h0101, 16'h0202, 16'h0303, 16'h0404);
        push_ready(t0);
        push_ev(t0 + 15, 4'd0, '0, 1'b0, 1'b1, 1'b0, 16'h0F0F);
        at_cyc(t0);
        start = 1'b0;
        dv_at(t0 + 14, 16'h0F0F);
        at_cyc(t0 + 18);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/operand_sequencer.md
OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 Parameter WIDTH, default 16: width of every operand and result bus.
REQ-002 Parameter HOLD, default 2, legal 1..15: number of cycles each select strobe is held.
REQ-003 Parameter TIMEOUT, default 1000, legal 1..65535: number of WAIT cycles allowed before giving up.
REQ-004 clk  in  1  clock; all state changes on the rising edge.
REQ-005 reset  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  host request to send one operand set; accepted only in IDLE.
REQ-007 abort  in  1  host cancel; returns the block to IDLE.
REQ-008 x_in, dx_in, a_in, u_in  in  WIDTH each  host operands; captured on start acceptance.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 sel  out  4  one-hot solver select: bit0 = s1/x, bit1 = s2/dx, bit2 = s3/a, bit3 = s4/u.
REQ-011 data_out  out  WIDTH  operand matching the active sel bit; 0 when sel is 0.
REQ-012 ready  out  1  solver go strobe.
REQ-013 dut_valid  in  1  solver completion level.
REQ-014 dut_result  in  WIDTH  solver result; qualified by dut_valid.
REQ-015 result  out  WIDTH  last captured dut_result; held until the next capture.
REQ-016 done  out  1  one-cycle pulse: result has been updated.
REQ-017 timeout  out  1  one-cycle pulse: the WAIT state expired without dut_valid.

Function
REQ-018 The FSM SHALL have the states IDLE, DRIVE, GAP, ARM, WAIT and REPORT, plus a 2-bit operand index and a 4-bit hold counter.
REQ-019 IDLE with start=1 SHALL, at that edge:
- latch all four operands;
- set index=0 and hold counter=0;
- go to DRIVE.
REQ-020 In DRIVE:
- sel SHALL equal 1<<index and data_out SHALL equal the operand at that index;
- after HOLD cycles, the next state SHALL be GAP.
REQ-021 GAP SHALL last exactly 1 cycle with sel=0 and data_out=0.
REQ-022 GAP SHALL go to DRIVE with index+1 when index<3, and SHALL go to ARM when index=3.
REQ-023 ARM SHALL assert ready for exactly 1 cycle, clear the timeout counter, and go to WAIT.
REQ-024 Latency from start acceptance to ready high SHALL be exactly 4*(HOLD+1)+1 cycles (default: 13).
REQ-025 WAIT SHALL sample dut_valid on each edge:
- dut_valid=1: capture dut_result into result and go to REPORT;
- dut_valid=0: increment the counter.
REQ-026 When the WAIT counter reaches TIMEOUT with dut_valid=0, the block SHALL pulse timeout for 1 cycle, leave result unchanged and return to IDLE.
REQ-027 If dut_valid=1 on the same edge the counter reaches TIMEOUT, capture SHALL win and timeout SHALL stay 0.
REQ-028 REPORT SHALL pulse done for 1 cycle and return to IDLE; back-to-back start is accepted on the cycle after REPORT.
REQ-029 start outside IDLE SHALL be ignored, and the latched operands SHALL NOT change.
REQ-030 abort=1 in any non-IDLE state SHALL force IDLE on the next edge:
- sel, ready, done and timeout low;
- result unchanged;
- abort has priority over every other transition.
REQ-031 dut_valid outside WAIT SHALL be ignored.
REQ-032 sel SHALL never have more than one bit set, and ready SHALL never be high while sel is nonzero.

Reset
REQ-033 While reset is high, the block SHALL be in IDLE with index=0 and both counters=0.
REQ-034 While reset is high, busy, sel, data_out, ready, done, timeout and result SHALL all be 0.
REQ-035 Reset asserted mid-sequence SHALL abandon the sequence immediately, with no done or timeout pulse.
REQ-036 The first start SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-037 A shared package SHALL hold the 3-bit state encodings and the sel bit-index constants (SEL_X=0, SEL_DX=1, SEL_A=2, SEL_U=3), reused by the solver controller's bench.
REQ-038 The WAIT counter SHALL be a sub-module named wait_timer, with ports clk, reset, clear, enable, limit and expired.
REQ-039 All outputs SHALL be registered.

Verification
REQ-040 The bench SHALL cover the nominal run:
- stimulus: HOLD=2; x=0x0010, dx=0x0001, a=0x0003, u=0x0005; start at cycle 0;
- sel sequence: 0001,0001,0000,0010,0010,0000,0100,0100,0000,1000,1000,0000;
- data_out matches sel;
- ready at cycle 13;
- dut_valid with 0x00AB 5 cycles later -> result=0x00AB, done one cycle.
REQ-041 The bench SHALL cover timeout: TIMEOUT=8 with no dut_valid -> timeout pulse 8 cycles after ready, result unchanged, busy low next cycle.
REQ-042 The bench SHALL cover the coincident edge: dut_valid on the exact expiry cycle -> done=1, timeout=0.
REQ-043 The bench SHALL cover start while busy: start pulsed during DRIVE of dx with new x=0xFFFF -> no restart, and the next sel=0001 cycle still drives 0x0010.
REQ-044 The bench SHALL cover abort and reset:
- abort during the a strobe -> sel=0 next cycle, busy low, no ready;
- reset during WAIT -> all outputs 0 immediately and no done.
